// File: rtl/npc_lsu_pkg.sv
// rtl/npc_lsu_pkg.sv - shared state type and response constants for the LSU AXI-lite master
package npc_lsu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5,
        HUNG    = 3'd6
    } lsu_state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // States in which an AXI transaction is outstanding and the watchdog runs
    function automatic logic is_busy(input lsu_state_t s);
        return (s == RD_ADDR) || (s == RD_DATA) || (s == WR_REQ) || (s == WR_RESP);
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// rtl/axi_lite_if.sv - AXI-lite channel bundle between the LSU and memory
interface axi_lite_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    modport master (
        output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wmask, bready,
        input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );

    modport slave (
        input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wmask, bready,
        output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/lsu_watchdog.sv
// rtl/lsu_watchdog.sv - per-transaction cycle watchdog, disabled when TIMEOUT_CYCLES is 0
module lsu_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Count enabled cycles since the last clear
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the cycle whose increment brings the count up to the limit
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            assign expired = en && !clr && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/lsu_axi_master.sv
// rtl/lsu_axi_master.sv - single-outstanding CPU load/store to AXI-lite master with watchdog
module lsu_axi_master
    import npc_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    axi_lite_if.master  mem
);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic        wen_q, wen_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        timed_out_q, timed_out_d;

    logic        accept;
    logic        wd_expired;

    assign accept = req_valid && (state_q == IDLE);

    lsu_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept),
        .en     (is_busy(state_q)),
        .expired(wd_expired)
    );

    // State and transaction registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            wen_q       <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            wen_q       <= wen_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            timed_out_q <= timed_out_d;
        end
    end

    // Next state and captured data; a watchdog expiry overrides any channel progress
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        wen_d       = wen_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        timed_out_d = timed_out_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    wmask_d     = req_wmask;
                    wen_d       = req_wen;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                    timed_out_d = 1'b0;
                    state_d     = req_wen ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (mem.arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (mem.rvalid) begin
                    rdata_d = mem.rdata;
                    err_d   = (mem.rresp != RESP_OKAY);
                    state_d = RESP;
                end
            end
            WR_REQ: begin
                // Each channel completes on its own; both may finish in one cycle
                aw_done_d = aw_done_q || mem.awready;
                w_done_d  = w_done_q || mem.wready;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (mem.bvalid) begin
                    err_d   = (mem.bresp != RESP_OKAY);
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = timed_out_q ? HUNG : IDLE;
                end
            end
            HUNG: begin
                state_d = HUNG;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (wd_expired) begin
            state_d     = RESP;
            rdata_d     = '0;
            err_d       = 1'b1;
            timed_out_d = 1'b1;
        end
    end

    // Handshake outputs decoded from the registered state only
    always_comb begin
        req_ready   = (state_q == IDLE);
        resp_valid  = (state_q == RESP);
        mem.arvalid = (state_q == RD_ADDR);
        mem.rready  = (state_q == RD_DATA);
        mem.awvalid = (state_q == WR_REQ) && !aw_done_q;
        mem.wvalid  = (state_q == WR_REQ) && !w_done_q;
        mem.bready  = (state_q == WR_RESP);
    end

    assign mem.araddr = addr_q;
    assign mem.awaddr = addr_q;
    assign mem.wdata  = wdata_q;
    assign mem.wmask  = wmask_q;
    assign resp_rdata = wen_q ? 32'd0 : rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// tb/tb_lsu_axi_master.sv - self-checking bench for lsu_axi_master
module tb_lsu_axi_master;

    localparam int WD_LIMIT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_req_valid, a_req_ready, a_req_wen, a_resp_valid, a_resp_ready, a_resp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic [7:0]  a_req_wmask;
    logic        b_rst, b_req_valid, b_req_ready, b_req_wen, b_resp_valid, b_resp_ready, b_resp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic [7:0]  b_req_wmask;

    axi_lite_if m0();
    axi_lite_if m1();

    lsu_axi_master u_dut_a (
        .clk(clk), .reset(a_rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wen(a_req_wen),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wmask(a_req_wmask),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .mem(m0)
    );

    lsu_axi_master #(.TIMEOUT_CYCLES(WD_LIMIT)) u_dut_b (
        .clk(clk), .reset(b_rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .mem(m1)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rcyc;
    } exp_t;

    exp_t exp_q[$];

    // Observations of the most recent transaction
    int          r_lat, r_viol, r_resp_cycles, r_aw_hold;
    logic [31:0] r_rdata, r_addr_seen;
    logic        r_err, r_hs_ok, r_accept, r_timeout;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_slave0();
        m0.arready = 1'b0; m0.rvalid = 1'b0; m0.rdata = '0; m0.rresp = '0;
        m0.awready = 1'b0; m0.wready = 1'b0; m0.bvalid = 1'b0; m0.bresp = '0;
    endtask

    // One request on DUT A against a slave with configurable wait states.
    // Tracks handshake counts and every valid/payload hold rule cycle by cycle.
    task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [7:0] wmask, input int aw_dly, input int w_dly,
                       input int ar_dly, input int d_dly, input logic [31:0] s_rdata,
                       input logic [1:0] s_resp, input int rdy_dly);
        int cyc = 0;
        int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, rsp_cnt = 0, r_cd = 0, b_cd = 0;
        int n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0, n_resp = 0;
        bit rv_on = 0, bv_on = 0, aw_done = 0, w_done = 0;
        bit ar_hs, aw_hs, w_hs, r_hs, b_hs;
        bit p_arv = 0, p_ar_hs = 0, p_awv = 0, p_aw_hs = 0, p_wv = 0, p_w_hs = 0;
        bit p_rspv = 0, p_rsp_hs = 0;
        logic [31:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0, p_rdata = '0;
        logic [7:0]  p_wmask = '0;
        logic        p_err = 1'b0;
        r_viol = 0; r_lat = -1; r_resp_cycles = 0; r_aw_hold = 0; r_timeout = 1'b0;
        r_rdata = 'x; r_err = 1'bx; r_addr_seen = 'x;
        r_accept = a_req_ready;
        a_req_valid = 1'b1; a_req_wen = wen; a_req_addr = addr;
        a_req_wdata = wdata; a_req_wmask = wmask;
        forever begin
            @(negedge clk);
            cyc++;
            a_req_valid = 1'b0;
            if (cyc > 200) begin
                r_timeout = 1'b1;
                break;
            end
            if (p_arv && !p_ar_hs && (m0.arvalid !== 1'b1 || m0.araddr !== p_araddr)) r_viol++;
            if (p_ar_hs && m0.arvalid !== 1'b0) r_viol++;
            if (p_awv && !p_aw_hs && (m0.awvalid !== 1'b1 || m0.awaddr !== p_awaddr)) r_viol++;
            if (p_aw_hs && m0.awvalid !== 1'b0) r_viol++;
            if (p_wv && !p_w_hs && (m0.wvalid !== 1'b1 || m0.wdata !== p_wdata || m0.wmask !== p_wmask)) r_viol++;
            if (p_w_hs && m0.wvalid !== 1'b0) r_viol++;
            if (p_rspv && !p_rsp_hs && (a_resp_valid !== 1'b1 || a_resp_rdata !== p_rdata || a_resp_err !== p_err)) r_viol++;
            if (p_rsp_hs) begin
                a_resp_ready = 1'b0;
                if (a_resp_valid !== 1'b0) r_viol++;
                break;
            end
            // Response channels from the slave
            if (r_cd > 0) begin r_cd--; if (r_cd == 0) rv_on = 1; end
            if (b_cd > 0) begin b_cd--; if (b_cd == 0) bv_on = 1; end
            m0.rvalid = rv_on; m0.rdata = rv_on ? s_rdata : 32'd0; m0.rresp = rv_on ? s_resp : 2'd0;
            m0.bvalid = bv_on; m0.bresp = bv_on ? s_resp : 2'd0;
            r_hs = rv_on && (m0.rready === 1'b1);
            b_hs = bv_on && (m0.bready === 1'b1);
            // Request channels: ready after the given number of valid cycles
            m0.arready = (m0.arvalid === 1'b1) && (ar_cnt >= ar_dly);
            m0.awready = (m0.awvalid === 1'b1) && (aw_cnt >= aw_dly);
            m0.wready  = (m0.wvalid === 1'b1) && (w_cnt >= w_dly);
            ar_hs = (m0.arvalid === 1'b1) && m0.arready;
            aw_hs = (m0.awvalid === 1'b1) && m0.awready;
            w_hs  = (m0.wvalid === 1'b1) && m0.wready;
            if (m0.arvalid === 1'b1) ar_cnt++;
            if (m0.awvalid === 1'b1) aw_cnt++;
            if (m0.wvalid === 1'b1) w_cnt++;
            if (w_done && m0.awvalid === 1'b1) r_aw_hold++;
            if (ar_hs) begin n_ar++; r_addr_seen = m0.araddr; r_cd = d_dly + 1; end
            if (aw_hs) begin n_aw++; aw_done = 1; r_addr_seen = m0.awaddr; end
            if (w_hs) begin
                n_w++; w_done = 1;
                if (m0.wdata !== wdata || m0.wmask !== wmask) r_viol++;
            end
            if ((aw_hs || w_hs) && aw_done && w_done) b_cd = d_dly + 1;
            if (r_hs) begin n_r++; rv_on = 0; end
            if (b_hs) begin n_b++; bv_on = 0; end
            // CPU response side
            p_rsp_hs = 0;
            if (a_resp_valid === 1'b1) begin
                if (r_lat < 0) begin
                    r_lat = cyc; r_rdata = a_resp_rdata; r_err = a_resp_err;
                end
                r_resp_cycles++;
                if (a_req_ready !== 1'b0) r_viol++;
                a_resp_ready = (rsp_cnt >= rdy_dly);
                rsp_cnt++;
                if (a_resp_ready) begin n_resp++; p_rsp_hs = 1; end
            end else begin
                a_resp_ready = 1'b0;
            end
            p_arv = (m0.arvalid === 1'b1); p_ar_hs = ar_hs; p_araddr = m0.araddr;
            p_awv = (m0.awvalid === 1'b1); p_aw_hs = aw_hs; p_awaddr = m0.awaddr;
            p_wv  = (m0.wvalid === 1'b1);  p_w_hs = w_hs; p_wdata = m0.wdata; p_wmask = m0.wmask;
            p_rspv = (a_resp_valid === 1'b1); p_rdata = a_resp_rdata; p_err = a_resp_err;
        end
        if (wen)
            r_hs_ok = (n_aw == 1) && (n_w == 1) && (n_b == 1) && (n_ar == 0) && (n_r == 0) && (n_resp == 1);
        else
            r_hs_ok = (n_ar == 1) && (n_r == 1) && (n_aw == 0) && (n_w == 0) && (n_b == 0) && (n_resp == 1);
        clear_slave0();
        a_resp_ready = 1'b0;
    endtask

    task automatic check_txn(input string tag, input exp_t e);
        check({tag, "_timeout"}, r_timeout, 1'b0);
        check({tag, "_accept"}, r_accept, 1'b1);
        check({tag, "_addr"}, r_addr_seen, e.addr);
        check({tag, "_rdata"}, r_rdata, e.rdata);
        check({tag, "_err"}, r_err, e.err);
        check({tag, "_latency"}, r_lat, e.lat);
        check({tag, "_handshakes"}, r_hs_ok, 1'b1);
        check({tag, "_protocol"}, r_viol, 0);
        check({tag, "_resp_cycles"}, r_resp_cycles, e.rcyc);
    endtask

    // Reference: response content and timing derived from the request and slave waits
    function automatic exp_t model(input logic wen, input logic [31:0] addr, input int aw_dly,
                                   input int w_dly, input int ar_dly, input int d_dly,
                                   input logic [31:0] s_rdata, input logic [1:0] s_resp,
                                   input int rdy_dly);
        exp_t e;
        e.wen   = wen;
        e.addr  = addr;
        e.rdata = wen ? 32'd0 : s_rdata;
        e.err   = (s_resp != 2'b00);
        e.lat   = wen ? ((aw_dly > w_dly ? aw_dly : w_dly) + d_dly + 3) : (ar_dly + d_dly + 3);
        e.rcyc  = rdy_dly + 1;
        return e;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        exp_t e;
        int first_resp, arv_cycles, bad;
        a_rst = 1'b0; a_req_valid = 1'b0; a_req_wen = 1'b0; a_req_addr = '0;
        a_req_wdata = '0; a_req_wmask = '0; a_resp_ready = 1'b0;
        b_rst = 1'b0; b_req_valid = 1'b0; b_req_wen = 1'b0; b_req_addr = '0;
        b_req_wdata = '0; b_req_wmask = '0; b_resp_ready = 1'b0;
        clear_slave0();
        m1.arready = 1'b0; m1.rvalid = 1'b0; m1.rdata = '0; m1.rresp = '0;
        m1.awready = 1'b0; m1.wready = 1'b0; m1.bvalid = 1'b0; m1.bresp = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_resp_valid", a_resp_valid, 1'b0);
        check("rst_axi_valids", {m0.arvalid, m0.awvalid, m0.wvalid, m0.rready, m0.bready}, 5'b0);
        a_rst = 1'b1; b_rst = 1'b1;
        @(negedge clk);
        check("rst_req_ready", a_req_ready, 1'b1);
        check("rst_resp_rdata", a_resp_rdata, 32'd0);
        check("rst_resp_err", a_resp_err, 1'b0);
        check("rst_b_req_ready", b_req_ready, 1'b1);

        // Zero-wait load
        txn(1'b0, 32'h8000_0010, 32'd0, 8'd0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 0);
        check_txn("load0", model(1'b0, 32'h8000_0010, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 0));

        // Back-to-back load with wait states
        txn(1'b0, 32'h8000_0020, 32'd0, 8'd0, 0, 0, 2, 1, 32'h0BAD_F00D, 2'b00, 0);
        check_txn("load_wait", model(1'b0, 32'h8000_0020, 0, 0, 2, 1, 32'h0BAD_F00D, 2'b00, 0));

        // Store with AW accepted three cycles after W
        txn(1'b1, 32'h8000_0100, 32'h1234_5678, 8'h0F, 3, 0, 0, 0, 32'd0, 2'b00, 0);
        check_txn("store_aw_late", model(1'b1, 32'h8000_0100, 3, 0, 0, 0, 32'd0, 2'b00, 0));
        check("store_aw_hold", r_aw_hold, 3);

        // Load slave error keeps the data
        txn(1'b0, 32'h8000_0200, 32'd0, 8'd0, 0, 0, 0, 0, 32'h0000_00AA, 2'b10, 0);
        check_txn("load_err", model(1'b0, 32'h8000_0200, 0, 0, 0, 0, 32'h0000_00AA, 2'b10, 0));

        // CPU stalls the response for five cycles
        txn(1'b0, 32'h8000_0300, 32'd0, 8'd0, 0, 0, 1, 0, 32'hCAFE_0123, 2'b00, 5);
        check_txn("resp_stall", model(1'b0, 32'h8000_0300, 0, 0, 1, 0, 32'hCAFE_0123, 2'b00, 5));

        // Store with W late and an error response
        txn(1'b1, 32'h8000_0400, 32'hA5A5_5A5A, 8'hF0, 0, 2, 0, 1, 32'd0, 2'b11, 0);
        check_txn("store_w_late", model(1'b1, 32'h8000_0400, 0, 2, 0, 1, 32'd0, 2'b11, 0));

        // Reset in the middle of a store that the slave never accepts
        a_req_valid = 1'b1; a_req_wen = 1'b1; a_req_addr = 32'h8000_0500;
        a_req_wdata = 32'h1111_2222; a_req_wmask = 8'hFF;
        @(negedge clk);
        a_req_valid = 1'b0;
        check("midrst_store_issued", {m0.awvalid, m0.wvalid}, 2'b11);
        a_rst = 1'b0;
        @(negedge clk);
        check("midrst_valids", {m0.awvalid, m0.wvalid, m0.arvalid, a_resp_valid}, 4'b0);
        a_rst = 1'b1;
        @(negedge clk);
        check("midrst_idle", a_req_ready, 1'b1);
        txn(1'b0, 32'h8000_0600, 32'd0, 8'd0, 0, 0, 0, 0, 32'h7777_8888, 2'b00, 0);
        check_txn("after_rst", model(1'b0, 32'h8000_0600, 0, 0, 0, 0, 32'h7777_8888, 2'b00, 0));

        // Random traffic: 200 same-cycle AW/W stores with random B delay, 40 random loads
        for (int i = 0; i < 240; i++) begin
            logic        wen;
            logic [31:0] addr, wdata, rdata;
            logic [7:0]  wmask;
            logic [1:0]  resp;
            int          ar_dly, d_dly, rdy;
            wen    = (i % 6) != 5;
            addr   = {$urandom} & 32'hFFFF_FFFC;
            wdata  = $urandom;
            rdata  = $urandom;
            wmask  = 8'($urandom);
            resp   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ar_dly = wen ? 0 : $urandom_range(0, 4);
            d_dly  = $urandom_range(0, 12);
            rdy    = $urandom_range(0, 2);
            exp_q.push_back(model(wen, addr, 0, 0, ar_dly, d_dly, rdata, resp, rdy));
            txn(wen, addr, wdata, wmask, 0, 0, ar_dly, d_dly, rdata, resp, rdy);
            e = exp_q.pop_front();
            check_txn(wen ? "rnd_store" : "rnd_load", e);
        end

        // Watchdog: slave never raises arready
        b_req_valid = 1'b1; b_req_wen = 1'b0; b_req_addr = 32'h8000_0040;
        check("wd_accept", b_req_ready, 1'b1);
        first_resp = -1; arv_cycles = 0;
        for (int c = 1; c <= 40 && first_resp < 0; c++) begin
            @(negedge clk);
            b_req_valid = 1'b0;
            if (b_resp_valid === 1'b1) first_resp = c;
            else if (m1.arvalid === 1'b1) arv_cycles++;
        end
        check("wd_resp_cycle", first_resp, 1 + WD_LIMIT);
        check("wd_arvalid_cycles", arv_cycles, WD_LIMIT);
        check("wd_err", b_resp_err, 1'b1);
        check("wd_rdata", b_resp_rdata, 32'd0);
        check("wd_axi_quiet", {m1.arvalid, m1.rready, m1.awvalid, m1.wvalid, m1.bready}, 5'b0);
        b_resp_ready = 1'b1;
        @(negedge clk);
        b_resp_ready = 1'b0;
        check("hung_resp_done", b_resp_valid, 1'b0);
        b_req_valid = 1'b1;
        bad = 0;
        repeat (5) begin
            if (b_req_ready !== 1'b0 || m1.arvalid !== 1'b0) bad++;
            @(negedge clk);
        end
        check("hung_holds", bad, 0);
        b_req_valid = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);
        b_rst = 1'b1;
        @(negedge clk);
        check("hung_reset_idle", b_req_ready, 1'b1);

        // Second run: reset in the middle of a read
        b_req_valid = 1'b1;
        @(negedge clk);
        b_req_valid = 1'b0;
        check("rd_rst_issued", m1.arvalid, 1'b1);
        @(negedge clk);
        b_rst = 1'b0;
        @(negedge clk);
        check("rd_rst_valids", {m1.arvalid, m1.awvalid, m1.wvalid, b_resp_valid, m1.rready, m1.bready}, 6'b0);
        b_rst = 1'b1;
        @(negedge clk);
        check("rd_rst_idle", b_req_ready, 1'b1);
        bad = 0;
        repeat (10) begin
            if (b_resp_valid !== 1'b0 || m1.arvalid !== 1'b0) bad++;
            @(negedge clk);
        end
        check("rd_rst_abandoned", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
